// File: rtl/div_32_seq_pkg.sv
// Shared constants, FSM encoding and sign helpers for the 32-bit sequential divider.
package div_32_seq_pkg;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned DIV_ITERS = 32;

    localparam logic [WIDTH-1:0] DZ_QUOTIENT = 32'hFFFF_FFFF;
    localparam logic [CNT_W-1:0] LAST_CNT    = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    // Two's-complement magnitude of a signed operand; unsigned operands pass through.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] value,
                                                   input logic             is_signed);
        logic [WIDTH-1:0] result;
        if (is_signed && value[WIDTH-1]) begin
            result = ~value + 32'd1;
        end else begin
            result = value;
        end
        return result;
    endfunction

    function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] value,
                                                     input logic             negate);
        logic [WIDTH-1:0] result;
        if (negate) begin
            result = ~value + 32'd1;
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/div_32_seq_cla.sv
// 32-bit carry-lookahead adder: eight 4-bit groups with group generate/propagate,
// exporting block-level generate/propagate so callers can form the carry-out.
module cla_32
    import div_32_seq_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] s,
    output logic             g_out,
    output logic             p_out
);

    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_c;
    logic [7:0]       w_gg;
    logic [7:0]       w_gp;
    logic [7:0]       w_gc;
    logic             w_gsum;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Per-group generate and propagate terms.
    always_comb begin
        w_gg = 8'h00;
        w_gp = 8'h00;
        for (int i = 0; i < 8; i++) begin
            w_gg[i] = w_g[4*i+3]
                    | (w_p[4*i+3] & w_g[4*i+2])
                    | (w_p[4*i+3] & w_p[4*i+2] & w_g[4*i+1])
                    | ((&w_p[4*i+3 -: 3]) & w_g[4*i]);
            w_gp[i] = &w_p[4*i +: 4];
        end
    end

    // Group carries, bit carries inside each group, and the block generate term.
    always_comb begin
        w_gc    = 8'h00;
        w_c     = 32'h0000_0000;
        w_gsum  = 1'b0;
        w_gc[0] = c_in;
        for (int i = 1; i < 8; i++) begin
            w_gc[i] = w_gg[i-1] | (w_gp[i-1] & w_gc[i-1]);
        end
        for (int i = 0; i < 8; i++) begin
            w_c[4*i] = w_gc[i];
            for (int k = 1; k < 4; k++) begin
                w_c[4*i+k] = w_g[4*i+k-1] | (w_p[4*i+k-1] & w_c[4*i+k-1]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            w_gsum = w_gg[i] | (w_gp[i] & w_gsum);
        end
    end

    assign s     = w_p ^ w_c;
    assign g_out = w_gsum;
    assign p_out = &w_gp;

endmodule

// File: rtl/div_32_seq.sv
// Multicycle restoring divider for DIV/DIVU/REM/REMU: one trial subtraction per
// cycle through cla_32, fixed 32-cycle latency from the accept edge.
module div_32_seq
    import div_32_seq_pkg::*;
(
    input  logic             clk,
    input  logic             clrn,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             ready
);

    state_e           r_state;
    state_e           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-2:0] r_p;
    logic [WIDTH-1:0] r_qacc;
    logic [WIDTH-1:0] r_a_raw;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dz;
    logic             r_busy;
    logic             r_ready;

    logic [WIDTH-1:0] w_t_in;
    logic [WIDTH-1:0] w_diff;
    logic             w_cla_g;
    logic             w_cla_p;
    logic             w_no_borrow;
    logic [WIDTH-1:0] w_p_next;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;
    logic             w_accept;
    logic             w_last;

    // The partial remainder stays below |b| <= 2^31, so 31 stored bits suffice.
    assign w_t_in = {r_p, r_d[WIDTH-1]};

    cla_32 u_trial_sub (
        .a     (w_t_in),
        .b     (~r_b),
        .c_in  (1'b1),
        .s     (w_diff),
        .g_out (w_cla_g),
        .p_out (w_cla_p)
    );

    assign w_no_borrow = w_cla_g | (w_cla_p & 1'b1);
    assign w_p_next    = w_no_borrow ? w_diff : w_t_in;
    assign w_q_next    = {r_qacc[WIDTH-2:0], w_no_borrow};
    assign w_last      = (r_state == S_RUN) && (r_cnt == LAST_CNT);
    assign w_accept    = (w_state_next == S_RUN) && (r_state != S_RUN);

    // Next-state decode: accept from IDLE or DONE, finish after the 32nd iteration.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (r_cnt == LAST_CNT) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_RUN;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Sign fix of the final quotient/remainder; divide-by-zero overrides both.
    always_comb begin
        w_q_fix = cond_negate(w_q_next, r_neg_q);
        w_r_fix = cond_negate(w_p_next, r_neg_r);
        if (r_dz) begin
            w_q_fix = DZ_QUOTIENT;
            w_r_fix = r_a_raw;
        end else begin
            w_q_fix = cond_negate(w_q_next, r_neg_q);
            w_r_fix = cond_negate(w_p_next, r_neg_r);
        end
    end

    // State register with registered busy/ready flags.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == S_RUN);
            r_ready <= (w_state_next == S_DONE);
        end
    end

    // Operand capture on accept, then one shift/subtract step per RUN cycle.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_cnt   <= 5'd0;
            r_d     <= 32'h0000_0000;
            r_b     <= 32'h0000_0000;
            r_p     <= 31'h0000_0000;
            r_qacc  <= 32'h0000_0000;
            r_a_raw <= 32'h0000_0000;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= 5'd0;
            r_d     <= magnitude(a, sign);
            r_b     <= magnitude(b, sign);
            r_p     <= 31'h0000_0000;
            r_qacc  <= 32'h0000_0000;
            r_a_raw <= a;
            r_neg_q <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_r <= sign & a[WIDTH-1];
            r_dz    <= (b == 32'h0000_0000);
        end else if (r_state == S_RUN) begin
            r_cnt  <= r_cnt + 5'd1;
            r_d    <= {r_d[WIDTH-2:0], 1'b0};
            r_p    <= w_p_next[WIDTH-2:0];
            r_qacc <= w_q_next;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Result registers load only at the completion edge and hold otherwise.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_q <= 32'h0000_0000;
            r_r <= 32'h0000_0000;
        end else if (w_last) begin
            r_q <= w_q_fix;
            r_r <= w_r_fix;
        end else begin
            r_q <= r_q;
            r_r <= r_r;
        end
    end

    assign q     = r_q;
    assign r     = r_r;
    assign busy  = r_busy;
    assign ready = r_ready;

endmodule

// File: tb/tb_div_32_seq.sv
// Self-checking bench for div_32_seq: directed corner cases plus random operands
// against a plain-arithmetic RISC-V division model.
module tb_div_32_seq;

    logic        clk = 1'b0;
    logic        clrn;
    logic        start;
    logic        sign;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        busy;
    logic        ready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    div_32_seq dut (
        .clk   (clk),
        .clrn  (clrn),
        .start (start),
        .sign  (sign),
        .a     (a),
        .b     (b),
        .q     (q),
        .r     (r),
        .busy  (busy),
        .ready (ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // RISC-V M-extension semantics computed with native arithmetic.
    function automatic void model(input logic [31:0] ta, input logic [31:0] tb,
                                  input logic ts,
                                  output logic [31:0] eq, output logic [31:0] er);
        int sa;
        int sb;
        if (tb == 32'd0) begin
            eq = 32'hFFFF_FFFF;
            er = ta;
        end else if (ts) begin
            if (ta == 32'h8000_0000 && tb == 32'hFFFF_FFFF) begin
                eq = 32'h8000_0000;
                er = 32'd0;
            end else begin
                sa = ta;
                sb = tb;
                eq = sa / sb;
                er = sa % sb;
            end
        end else begin
            eq = ta / tb;
            er = ta % tb;
        end
    endfunction

    task automatic launch(input logic [31:0] ta, input logic [31:0] tb, input logic ts);
        a     = ta;
        b     = tb;
        sign  = ts;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Counts cycles until ready (bounded), checking busy stays high meanwhile.
    task automatic await_ready(input string tag, input int exp_lat);
        int lat     = 0;
        bit busy_ok = 1'b1;
        while (ready !== 1'b1 && lat < 60) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            tick();
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
        check({tag, " ready"}, {31'd0, ready}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                          input logic ts);
        logic [31:0] eq;
        logic [31:0] er;
        model(ta, tb, ts, eq, er);
        launch(ta, tb, ts);
        await_ready(tag, 32);
        check({tag, " q"}, q, eq);
        check({tag, " r"}, r, er);
        tick();
        check({tag, " ready one cycle"}, {31'd0, ready}, 32'd0);
        check({tag, " q held"}, q, eq);
    endtask

    initial begin
        logic [31:0] eq;
        logic [31:0] er;
        logic [31:0] eq2;
        logic [31:0] er2;
        logic [31:0] ra;
        logic [31:0] rb;
        bit          quiet;

        clrn  = 1'b0;
        start = 1'b0;
        sign  = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        tick();
        tick();
        check("reset q", q, 32'd0);
        check("reset r", r, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset ready", {31'd0, ready}, 32'd0);
        clrn = 1'b1;
        tick();

        run_op("u 100/7", 32'd100, 32'd7, 1'b0);
        check("u 100/7 q const", q, 32'd14);
        check("u 100/7 r const", r, 32'd2);
        run_op("s -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1);
        check("s -7/2 q const", q, 32'hFFFF_FFFD);
        check("s -7/2 r const", r, 32'hFFFF_FFFF);
        run_op("s 7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1);
        run_op("u 5/0", 32'd5, 32'd0, 1'b0);
        run_op("s -5/0", 32'hFFFF_FFFB, 32'd0, 1'b1);
        check("s -5/0 r const", r, 32'hFFFF_FFFB);
        run_op("s ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_op("u ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("u ovf r const", r, 32'h8000_0000);

        // start pulsed mid-RUN with new operands must be ignored
        model(32'd1000, 32'd3, 1'b0, eq, er);
        launch(32'd1000, 32'd3, 1'b0);
        repeat (9) tick();
        a     = 32'd55;
        b     = 32'd5;
        sign  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        await_ready("ignore start", 22);
        check("ignore start q", q, eq);
        check("ignore start r", r, er);
        tick();

        // reset at E15 discards the operation
        launch(32'd12345, 32'd67, 1'b0);
        repeat (14) tick();
        clrn = 1'b0;
        tick();
        clrn = 1'b1;
        check("midrun reset busy", {31'd0, busy}, 32'd0);
        check("midrun reset ready", {31'd0, ready}, 32'd0);
        check("midrun reset q", q, 32'd0);
        check("midrun reset r", r, 32'd0);
        quiet = 1'b1;
        repeat (40) begin
            if (ready !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
            tick();
        end
        check("after reset quiet", {31'd0, quiet}, 32'd1);

        // back-to-back accept while ready is high
        model(32'd999, 32'd10, 1'b0, eq, er);
        model(32'hFFFF_FF00, 32'd16, 1'b1, eq2, er2);
        launch(32'd999, 32'd10, 1'b0);
        await_ready("b2b first", 32);
        check("b2b first q", q, eq);
        check("b2b first r", r, er);
        a     = 32'hFFFF_FF00;
        b     = 32'd16;
        sign  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b accept busy", {31'd0, busy}, 32'd1);
        check("b2b first q held", q, eq);
        await_ready("b2b second", 32);
        check("b2b second q", q, eq2);
        check("b2b second r", r, er2);
        tick();

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 20);
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            run_op("rand", ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
